wbxwatchdog: RTL and testbench



---
 rtl/wbxwatchdog.sv | 98 +++++++++
 tb/tb_wbxwatchdog.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wbxwatchdog.sv
// wbxwatchdog: zero-latency Wishbone pipeline watchdog that errors the master and aborts downstream on a stall timeout.
// Optional WBXWATCHDOG_STATUS_EN adds a saturating o_fault_count output.
module wbxwatchdog #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LGDEPTH   = 5,
    parameter int LGTIMEOUT = 10,
    parameter int TIMEOUT   = 1000
) (
`ifdef WBXWATCHDOG_STATUS_EN
    output logic [15:0]     o_fault_count,
`endif
    input  logic            i_wb_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_dn_cyc,
    output logic            o_dn_stb,
    output logic            o_dn_we,
    output logic [AW-1:0]   o_dn_addr,
    output logic [DW-1:0]   o_dn_data,
    output logic [DW/8-1:0] o_dn_sel,
    input  logic            i_dn_stall,
    input  logic            i_dn_ack,
    input  logic            i_dn_err,
    input  logic [DW-1:0]   i_dn_data
);
    typedef enum logic [1:0] {IDLE, BUSY, FAULT, DRAIN} state_t;
    localparam logic [LGTIMEOUT-1:0] RELOAD = LGTIMEOUT'(TIMEOUT - 1);
    state_t state;
    logic [LGDEPTH-1:0] count, count_n;
    logic [LGTIMEOUT-1:0] timer;
    logic active, full, accept, retire, busy;
    assign active     = i_reset_n && (state == IDLE || state == BUSY);
    assign full       = &count;
    assign o_dn_cyc   = active && i_wb_cyc;
    assign o_dn_stb   = active && i_wb_stb && !full;
    assign o_dn_we    = i_wb_we;
    assign o_dn_addr  = i_wb_addr;
    assign o_dn_data  = i_wb_data;
    assign o_dn_sel   = i_wb_sel;
    assign o_wb_stall = !active || i_dn_stall || full;
    assign o_wb_ack   = o_dn_cyc && i_dn_ack;
    assign o_wb_err   = (o_dn_cyc && i_dn_err) || (i_reset_n && state == FAULT);
    assign o_wb_data  = i_dn_data;
    assign accept     = i_wb_stb && !o_wb_stall;
    assign retire     = o_dn_cyc && (i_dn_ack || i_dn_err);
    assign count_n    = count + LGDEPTH'(accept) - LGDEPTH'(retire);
    // A stalled request with nothing outstanding still counts as waiting on downstream.
    assign busy       = i_wb_cyc && (count != '0 || (i_wb_stb && o_wb_stall));
    always_ff @(posedge i_wb_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            count <= '0;
            timer <= RELOAD;
        end else begin
            case (state)
                IDLE, BUSY: begin
                    if (!i_wb_cyc) begin
                        state <= IDLE;
                        count <= '0;
                        timer <= RELOAD;
                    end else if (busy && !accept && !retire) begin
                        state <= (timer == LGTIMEOUT'(1)) ? FAULT : BUSY;
                        timer <= timer - LGTIMEOUT'(1);
                    end else begin
                        state <= (count_n != '0) ? BUSY : IDLE;
                        count <= count_n;
                        timer <= RELOAD;
                    end
                end
                FAULT: begin
                    state <= DRAIN;
                    count <= '0;
                    timer <= RELOAD;
                end
                DRAIN:   state <= i_wb_cyc ? DRAIN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef WBXWATCHDOG_STATUS_EN
    always_ff @(posedge i_wb_clk) begin
        if (!i_reset_n)
            o_fault_count <= '0;
        else if (state == FAULT && o_fault_count != 16'hFFFF)
            o_fault_count <= o_fault_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wbxwatchdog.sv
// tb_wbxwatchdog: directed table and sequence checks for wbxwatchdog (LGDEPTH=2, TIMEOUT=8).
module tb_wbxwatchdog;
    logic clk = 0;
    logic rn, cyc, stb, we, dst, dack, derr;
    logic [31:0] addr, wdata, ddata;
    logic [3:0] sel;
    logic stall, wack, werr, dcyc, dstb, dwe;
    logic [31:0] rdata, daddr, ddat;
    logic [3:0] dsel;
    logic [4:0] outs;
`ifdef WBXWATCHDOG_STATUS_EN
    logic [15:0] fcount;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    wbxwatchdog #(.AW(32), .DW(32), .LGDEPTH(2), .LGTIMEOUT(10), .TIMEOUT(8)) dut (
`ifdef WBXWATCHDOG_STATUS_EN
        .o_fault_count(fcount),
`endif
        .i_wb_clk(clk), .i_reset_n(rn),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(wack), .o_wb_err(werr), .o_wb_data(rdata),
        .o_dn_cyc(dcyc), .o_dn_stb(dstb), .o_dn_we(dwe),
        .o_dn_addr(daddr), .o_dn_data(ddat), .o_dn_sel(dsel),
        .i_dn_stall(dst), .i_dn_ack(dack), .i_dn_err(derr), .i_dn_data(ddata)
    );

    // {dn_cyc, dn_stb, wb_stall, wb_ack, wb_err}
    assign outs = {dcyc, dstb, stall, wack, werr};

    typedef struct {
        logic rn, cyc, stb, dst, ack, err;
        logic [31:0] dat;
        logic [4:0] exp;
    } vec_t;
    vec_t vec[$];

    function automatic vec_t v(input logic r, c, s, d, a, e, input logic [31:0] dt, input logic [4:0] x);
        vec_t t;
        t.rn = r; t.cyc = c; t.stb = s; t.dst = d; t.ack = a; t.err = e; t.dat = dt; t.exp = x;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, c, s, d, a, e, input logic [31:0] dt);
        @(negedge clk);
        rn = r; cyc = c; stb = s; dst = d; dack = a; derr = e; ddata = dt;
        #1;
    endtask

    task automatic timeout_seq(input string tag);
        we = 1;
        drive(1, 1, 1, 0, 0, 0, 0); chk({tag, " accept"}, outs, 5'b11000);
        for (int k = 1; k < 8; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0); chk({tag, " wait"}, outs, 5'b10000);
        end
        drive(1, 1, 0, 0, 1, 0, 0); chk({tag, " fault"}, outs, 5'b00101);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0); chk({tag, " drain"}, outs, 5'b00100);
        end
        drive(1, 0, 0, 0, 0, 0, 0); chk({tag, " drain cyc low"}, outs, 5'b00100);
        drive(1, 0, 0, 0, 0, 0, 0); chk({tag, " idle"}, outs, 5'b00000);
        we = 0;
    endtask

    initial begin
        rn = 0; cyc = 0; stb = 0; we = 0; dst = 0; dack = 0; derr = 0;
        addr = 0; wdata = 0; ddata = 0; sel = 0;
        vec.push_back(v(0, 1, 1, 0, 0, 0, 0, 5'b00100));
        vec.push_back(v(0, 0, 0, 0, 0, 0, 0, 5'b00100));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 0, 0, 0, 0, 0, 5'b10000));
        vec.push_back(v(1, 1, 0, 0, 0, 0, 0, 5'b10000));
        vec.push_back(v(1, 1, 0, 0, 1, 0, 32'hDEADBEEF, 5'b10010));
        vec.push_back(v(1, 0, 0, 0, 0, 0, 0, 5'b00000));
        vec.push_back(v(1, 1, 1, 1, 0, 0, 0, 5'b11100));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 0, 0, 0, 1, 0, 5'b10001));
        vec.push_back(v(1, 0, 0, 0, 0, 0, 0, 5'b00000));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b10100));
        vec.push_back(v(1, 1, 1, 0, 1, 0, 32'h11112222, 5'b10110));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b10100));
        vec.push_back(v(1, 1, 0, 0, 1, 0, 32'h33334444, 5'b10110));
        vec.push_back(v(1, 1, 1, 0, 1, 0, 32'h55556666, 5'b11010));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 0, 0, 0, 0, 0, 0, 5'b00100));
        vec.push_back(v(1, 1, 1, 0, 0, 0, 0, 5'b11000));
        vec.push_back(v(1, 0, 0, 0, 0, 0, 0, 5'b00000));
        foreach (vec[i]) begin
            addr = 32'hA000_0000 | 32'(i);
            wdata = ~addr;
            sel = 4'(i);
            we = addr[0];
            drive(vec[i].rn, vec[i].cyc, vec[i].stb, vec[i].dst, vec[i].ack, vec[i].err, vec[i].dat);
            chk($sformatf("vec%0d outs", i), outs, vec[i].exp);
            chk($sformatf("vec%0d pass", i), {dwe, dsel, daddr, ddat}, {we, sel, addr, wdata});
            if (vec[i].exp[1]) chk($sformatf("vec%0d rdata", i), rdata, vec[i].dat);
        end
`ifdef WBXWATCHDOG_STATUS_EN
        chk("fault count after reset", 64'(fcount), 0);
`endif
        timeout_seq("to1");
        drive(1, 1, 1, 0, 0, 0, 0); chk("post-fault accept", outs, 5'b11000);
        drive(1, 1, 0, 0, 1, 0, 32'h0BADF00D); chk("post-fault ack", outs, 5'b10010);
        drive(1, 0, 0, 0, 0, 0, 0);
        // Retire on the last cycle before expiry reloads the timer each time.
        drive(1, 1, 1, 0, 0, 0, 0); chk("edge acc0", outs, 5'b11000);
        drive(1, 1, 1, 0, 0, 0, 0); chk("edge acc1", outs, 5'b11000);
        for (int k = 2; k < 8; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0); chk("edge wait a", outs, 5'b10000);
        end
        drive(1, 1, 0, 0, 1, 0, 32'hCAFEF00D); chk("edge ack1", outs, 5'b10010);
        chk("edge ack1 data", rdata, 32'hCAFEF00D);
        for (int k = 9; k < 15; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0); chk("edge wait b", outs, 5'b10000);
        end
        drive(1, 1, 0, 0, 1, 0, 32'h12345678); chk("edge ack2", outs, 5'b10010);
        drive(1, 0, 0, 0, 0, 0, 0); chk("edge done", outs, 5'b00000);
        drive(1, 1, 1, 0, 0, 0, 0); chk("edge second acc", outs, 5'b11000);
        drive(1, 1, 0, 0, 1, 0, 32'h9ABCDEF0); chk("edge second ack", outs, 5'b10010);
        drive(1, 0, 0, 0, 0, 0, 0);
`ifdef WBXWATCHDOG_STATUS_EN
        timeout_seq("to2");
        timeout_seq("to3");
        chk("fault count three", 64'(fcount), 3);
`endif
        drive(1, 1, 1, 0, 0, 0, 0); chk("rst acc0", outs, 5'b11000);
        drive(1, 1, 1, 0, 0, 0, 0); chk("rst acc1", outs, 5'b11000);
        drive(0, 1, 1, 0, 1, 1, 0); chk("in reset", outs, 5'b00100);
        begin
            logic bad = 0;
            for (int k = 0; k < 12; k++) begin
                drive(1, 1, 0, 0, 0, 0, 0);
                if (outs !== 5'b10000) bad = 1;
            end
            chk("post-reset quiet", 64'(bad), 0);
        end
`ifdef WBXWATCHDOG_STATUS_EN
        chk("fault count cleared", 64'(fcount), 0);
`endif
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0); chk("post-reset acc", outs, 5'b11000);
        drive(1, 1, 0, 0, 1, 0, 32'hFEEDFACE); chk("post-reset ack", outs, 5'b10010);
        chk("post-reset data", rdata, 32'hFEEDFACE);
        drive(1, 0, 0, 0, 0, 0, 0); chk("final idle", outs, 5'b00000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
